// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : UART receive path. Synchronises the raw serial line, recovers
//             frame timing from an oversampling baud tick, deserialises the
//             data bits LSB first, checks parity and stop bit, and strobes out
//             one word per frame with error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_WIDTH  = 8,   // data bits per frame (5..9)
  parameter int OVERSAMPLE  = 16,  // baud ticks per bit period (even, >= 8)
  parameter int SYNC_STAGES = 2    // synchroniser depth on rx_in (>= 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  // Mid-start sample point and full-bit sample point, as tick-counter values
  localparam logic [TW-1:0] C_TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] C_TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [TW-1:0]          tick_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic                   par_en_q;
  logic                   par_odd_q;
  logic                   par_mis_q;
  logic [DATA_WIDTH-1:0]  rx_data_q;
  logic                   rx_valid_q;
  logic                   parity_err_q;
  logic                   frame_err_q;
  logic                   busy_q;

  // Metastability synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Frame FSM: counters and state only move on baud ticks; outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_mis_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // The strobe is a single clock wide regardless of tick spacing
      rx_valid_q <= 1'b0;
      if (baud_tick) begin
        unique case (state_q)
          S_IDLE: begin
            if (!rx_s) begin
              state_q <= S_START;
              tick_q  <= '0;
              busy_q  <= 1'b1;
            end
          end

          S_START: begin
            if (tick_q == C_TICK_HALF) begin
              tick_q <= '0;
              if (rx_s) begin
                // Line went back high before mid-start: treat as a glitch
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                // Frame format is latched here and held for the whole frame
                state_q   <= S_DATA;
                bit_q     <= '0;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                par_mis_q <= 1'b0;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end

          S_DATA: begin
            if (tick_q == C_TICK_FULL) begin
              tick_q  <= '0;
              // Shifting in from the top leaves the first (LSB) bit at bit 0
              shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
              if (bit_q == C_BIT_LAST) begin
                bit_q   <= '0;
                state_q <= par_en_q ? S_PARITY : S_STOP;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end

          S_PARITY: begin
            if (tick_q == C_TICK_FULL) begin
              tick_q    <= '0;
              // Mismatch when received bit differs from XOR(data) ^ odd
              par_mis_q <= rx_s ^ (^shift_q) ^ par_odd_q;
              state_q   <= S_STOP;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end

          S_STOP: begin
            if (tick_q == C_TICK_FULL) begin
              tick_q       <= '0;
              rx_data_q    <= shift_q;
              parity_err_q <= par_en_q & par_mis_q;
              frame_err_q  <= ~rx_s;
              rx_valid_q   <= 1'b1;
              if (rx_s) begin
                // Leaving mid stop bit lets a back-to-back start be caught
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_WAIT_HIGH;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end

          S_WAIT_HIGH: begin
            // Break or framing error: ignore the line until it returns high
            if (rx_s) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end

          default: begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Self-checking bench for uart_rx. Frames are driven bit by bit,
//             expected words are queued when a frame is driven and compared
//             when the receiver strobes rx_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int DW       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_tick = 1'b0;
  logic          rx_in = 1'b1;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          parity_err;
  logic          frame_err;
  logic          rx_busy;

  uart_rx #(
    .DATA_WIDTH (DW),
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx_in     (rx_in),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Baud tick: one clock in every TICK_DIV, changed away from the active edge
  int tick_div = 0;
  always @(negedge clk) begin
    baud_tick = (tick_div == 0);
    tick_div  = (tick_div + 1) % TICK_DIV;
  end

  longint cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  longint valid_cyc[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_valid = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued frame
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid++;
      valid_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("sb_nonempty", 32'(exp_q.size()), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("rx_data",    32'(rx_data),    32'(mon_e.data));
        check_eq("parity_err", 32'(parity_err), 32'(mon_e.perr));
        check_eq("frame_err",  32'(frame_err),  32'(mon_e.ferr));
      end
    end
  end

  function automatic bit par_of(input logic [DW-1:0] d, input bit odd);
    return (^d) ^ odd;
  endfunction

  task automatic push_exp(input logic [DW-1:0] d, input bit pen, input bit podd,
                          input bit pbit, input bit stopb);
    exp_t e;
    e.data = d;
    e.perr = pen ? (pbit != par_of(d, podd)) : 1'b0;
    e.ferr = ~stopb;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input bit b);
    rx_in = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit pen, input bit pbit,
                            input bit stopb);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stopb);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"},  32'(rx_data),    0);
    check_eq({tag, "_valid"}, 32'(rx_valid),   0);
    check_eq({tag, "_perr"},  32'(parity_err), 0);
    check_eq({tag, "_ferr"},  32'(frame_err),  0);
    check_eq({tag, "_busy"},  32'(rx_busy),    0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    bit  pb;
    // Reset state
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // 8N1 frame 0xA5
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_drain("a5_drain");
    repeat (BIT_CLKS) @(negedge clk);
    check_eq("a5_busy_low", 32'(rx_busy), 0);
    check_eq("a5_data_hold", 32'(rx_data), 32'h0A5);
    check_eq("a5_count", 32'(n_valid), 1);

    // Even parity 0x3C: correct parity bit, then inverted parity bit
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    pb = par_of(8'h3C, 1'b0);
    push_exp(8'h3C, 1'b1, 1'b0, pb, 1'b1);
    send_frame(8'h3C, 1'b1, pb, 1'b1);
    push_exp(8'h3C, 1'b1, 1'b0, ~pb, 1'b1);
    send_frame(8'h3C, 1'b1, ~pb, 1'b1);
    wait_drain("par_drain");
    check_eq("par_count", 32'(n_valid), 3);
    parity_en = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);

    // 0x55 with stop bit low, then line held low for a break
    push_exp(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (3 * BIT_CLKS) @(negedge clk);
    check_eq("brk_count", 32'(n_valid), 4);
    check_eq("brk_busy_wait", 32'(rx_busy), 1);
    rx_in = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    check_eq("brk_busy_low", 32'(rx_busy), 0);
    check_eq("brk_ferr_hold", 32'(frame_err), 1);
    check_eq("brk_no_extra", 32'(n_valid), 4);
    repeat (BIT_CLKS) @(negedge clk);

    // Short low glitch (5 ticks) in idle
    rx_in = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("glitch_busy_high", 32'(rx_busy), 1);
    repeat (8) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_busy_low", 32'(rx_busy), 0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_eq("glitch_no_valid", 32'(n_valid), 4);

    // Three back-to-back frames with a single stop bit
    base = valid_cyc.size();
    push_exp(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    push_exp(8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    push_exp(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    wait_drain("b2b_drain");
    check_eq("b2b_count", 32'(valid_cyc.size() - base), 3);
    if (valid_cyc.size() >= base + 3) begin
      check_eq("b2b_space1", 32'(valid_cyc[base+1] - valid_cyc[base]),   10 * BIT_CLKS);
      check_eq("b2b_space2", 32'(valid_cyc[base+2] - valid_cyc[base+1]), 10 * BIT_CLKS);
    end
    repeat (BIT_CLKS) @(negedge clk);

    // Reset in the middle of bit 4 of frame 0x0F, then frame 0x12
    base = n_valid;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_in = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    check_eq("abort_busy_pre", 32'(rx_busy), 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("abort_rst");
    rx_in = 1'b1;
    rst   = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_eq("abort_no_valid", 32'(n_valid - base), 0);
    push_exp(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    wait_drain("abort_drain");
    check_eq("abort_count", 32'(n_valid - base), 1);

    repeat (BIT_CLKS) @(negedge clk);
    check_eq("total_valid", 32'(n_valid), 8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive path, the mirror of the transmit datapath. It deserialises an asynchronous serial line into parallel words. It recovers frame timing from a 16x oversampling tick and checks parity and stop bits. It sits between the pad-side rx line and the receive buffer or host interface, and delivers one word per frame with a single-cycle valid strobe and error flags.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9), LSB first on the line
OVERSAMPLE, 16, baud ticks per bit period (even, >= 8)
SYNC_STAGES, 2, metastability synchroniser depth on rx_in (>= 2)

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  asynchronous, active-high reset
baud_tick  input  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate
rx_in  input  1  raw serial line, idle high, asynchronous to clk
parity_en  input  1  1 = frame carries a parity bit after the data bits
parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en=0
rx_data  output  DATA_WIDTH  last received word; held until next rx_valid
rx_valid  output  1  one-clk pulse: rx_data and error flags updated
parity_err  output  1  parity mismatch on the last frame; updated with rx_valid
frame_err  output  1  stop bit sampled low on the last frame; updated with rx_valid
rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; rx_data=0; rx_valid=0; parity_err=0; frame_err=0; rx_busy=0; all synchroniser flops=1; tick and bit counters=0.
- rx_in passes through SYNC_STAGES flops, giving rx_s. FSM decisions use only rx_s.
- Tick counter and bit counter advance only on clocks where baud_tick=1. The state does not change on non-tick clocks.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: count OVERSAMPLE/2 ticks, then sample mid-bit.
  - rx_s=1 means a glitch or false start: return to IDLE with no rx_valid.
  - rx_s=0 means the start bit is confirmed: go to DATA with tick_cnt=0 and bit_cnt=0.
- DATA: every OVERSAMPLE ticks, sample rx_s into shift register bit position bit_cnt (LSB first). After DATA_WIDTH samples, go to PARITY if parity_en=1, else go to STOP.
- PARITY: after OVERSAMPLE ticks, sample rx_s.
  - Expected parity is the XOR of the data bits, inverted when parity_odd=1.
  - Capture mismatch in an internal flag. Go to STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - On the next clk edge: rx_data <= shift reg; parity_err <= mismatch flag (0 if parity_en=0); frame_err <= ~sample; rx_valid=1 for exactly one clk.
  - If the sample was 1, go to IDLE.
  - If the sample was 0 (framing error or break), go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick with rx_s=1, then go to IDLE. No further rx_valid is produced during a held-low break.
- parity_en and parity_odd are sampled once, at the START→DATA transition, and held for the frame. Mid-frame changes have no effect.
- Latency: rx_valid rises 1 clk after the baud_tick on which the stop bit is sampled. That tick falls OVERSAMPLE/2 + (DATA_WIDTH + parity_en + 1)*OVERSAMPLE ticks after the first tick that sees rx_s=0.
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge arriving immediately after a full-length stop bit is detected with no frame loss.
- No backpressure: rx_valid is a strobe, and a consumer that misses it loses the word. rx_data and the flags stay stable between strobes.
- rst asserted mid-frame: the frame is aborted immediately, all outputs return to reset values, and no rx_valid is issued for the aborted frame.
- baud_tick held low: the FSM freezes in its current state and outputs hold.

Test Plan:
- Frame 0xA5, 8N1, OVERSAMPLE=16, baud_tick every 4 clks -> single rx_valid pulse; rx_data=0xA5; parity_err=0; frame_err=0; rx_busy low afterwards.
- Frame 0x3C, parity_en=1, parity_odd=0, correct parity bit 0, then repeated with parity bit forced 1 -> first frame parity_err=0, second frame parity_err=1; rx_data=0x3C both times.
- Frame 0x55 with stop bit driven 0, then line held low 3 bit-times -> one rx_valid with frame_err=1, rx_data=0x55. FSM stays in WAIT_HIGH, with no second rx_valid until the line returns high.
- Line low pulse of 5 ticks (< OVERSAMPLE/2) in IDLE -> no rx_valid; rx_busy returns low at the mid-start check.
- Three back-to-back frames 0x01, 0x80, 0xFF with minimal 1-bit stop -> three rx_valid pulses, each spaced exactly 10 bit periods, with data in order.
- rst asserted during bit 4 of frame 0x0F, released, then frame 0x12 sent -> no strobe for 0x0F; outputs at reset values during rst; next rx_valid carries 0x12 with no errors.
